// File: rtl/ifu_litebpu_pkg.sv
// Shared widths, FSM encodings and constants for the IFU lite branch-prediction unit.
package ifu_litebpu_pkg;

    localparam int XLEN        = 32;
    localparam int PC_SIZE     = 32;
    localparam int RFIDX_WIDTH = 5;

    localparam logic [PC_SIZE-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        BPU_ST_IDLE = 2'd0,
        BPU_ST_WAIT = 2'd1,
        BPU_ST_REQ  = 2'd2,
        BPU_ST_DATA = 2'd3
    } bpu_state_e;

endpackage

// File: rtl/ifu_litebpu_dfflr.sv
// Generic load-enabled register with asynchronous active-high reset.
module ifu_litebpu_dfflr #(
    parameter int              DW      = 1,
    parameter logic [DW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    logic [DW-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else if (lden) begin
            data_q <= dnxt;
        end
    end

    assign qout = data_q;

endmodule

// File: rtl/ifu_litebpu.sv
// Static branch predictor: selects next-PC adder operands and fetches the JALR base
// register, stalling fetch on dependencies. Exposes the FSM state on bpu_state_dbg.
module ifu_litebpu
    import ifu_litebpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_SIZE-1:0]     pc,
    input  logic                   dec_i_valid,
    input  logic                   dec_bjp,
    input  logic                   dec_jal,
    input  logic                   dec_jalr,
    input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
    input  logic [XLEN-1:0]        dec_bjp_imm,
    input  logic                   ifu_o_hsked,
    input  logic                   flush,
    input  logic                   oitf_empty,
    input  logic                   ir_valid,
    input  logic                   ir_rdwen,
    input  logic [RFIDX_WIDTH-1:0] ir_rdidx,
    input  logic [XLEN-1:0]        rf2bpu_x1,
    output logic                   bpu2rf_rd_req,
    output logic [RFIDX_WIDTH-1:0] bpu2rf_rs1idx,
    input  logic                   rf2bpu_rd_gnt,
    input  logic [XLEN-1:0]        rf2bpu_rs1,
    output logic                   prdt_taken,
    output logic [PC_SIZE-1:0]     prdt_pc_add_op1,
    output logic [PC_SIZE-1:0]     prdt_pc_add_op2,
    output logic                   bpu_wait,
    output logic [1:0]             bpu_state_dbg
);

    // Read-port handshake: bpu2rf_rd_req is held high until rf2bpu_rd_gnt is seen
    // high in the same cycle; rf2bpu_rs1 is then sampled one cycle later (DATA).
    bpu_state_e             state_q, state_d;
    logic [RFIDX_WIDTH-1:0] rs1idx_q, rs1idx_d;
    logic                   rs1idx_ld;

    logic jalr_vld, rs1_x0, rs1_x1, jalr_xn_vld;
    logic x1_dep, xn_dep;

    assign jalr_vld    = dec_i_valid & dec_jalr;
    assign rs1_x0      = (dec_jalr_rs1idx == '0);
    assign rs1_x1      = (dec_jalr_rs1idx == RFIDX_WIDTH'(1));
    assign jalr_xn_vld = jalr_vld & ~rs1_x0 & ~rs1_x1;
    assign x1_dep      = ~oitf_empty | (ir_valid & ir_rdwen & (ir_rdidx == RFIDX_WIDTH'(1)));
    assign xn_dep      = ~oitf_empty | ir_valid;

    ifu_litebpu_dfflr #(.DW(2), .RST_VAL(BPU_ST_IDLE)) u_state_dff (
        .clk  (clk),
        .rst  (rst),
        .lden (1'b1),
        .dnxt (state_d),
        .qout (state_q)
    );

    ifu_litebpu_dfflr #(.DW(RFIDX_WIDTH), .RST_VAL('0)) u_rs1idx_dff (
        .clk  (clk),
        .rst  (rst),
        .lden (rs1idx_ld),
        .dnxt (rs1idx_d),
        .qout (rs1idx_q)
    );

    assign rs1idx_d  = dec_jalr_rs1idx;
    assign rs1idx_ld = (state_q == BPU_ST_IDLE) & jalr_xn_vld & ~flush;

    // With no dependency at detection we skip WAIT so the request lands in the next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BPU_ST_IDLE: if (jalr_xn_vld) state_d = xn_dep ? BPU_ST_WAIT : BPU_ST_REQ;
            BPU_ST_WAIT: if (~xn_dep)        state_d = BPU_ST_REQ;
            BPU_ST_REQ:  if (rf2bpu_rd_gnt)  state_d = BPU_ST_DATA;
            BPU_ST_DATA: if (ifu_o_hsked)    state_d = BPU_ST_IDLE;
            default:                         state_d = BPU_ST_IDLE;
        endcase
        if (flush) state_d = BPU_ST_IDLE;
    end

    always_comb begin
        prdt_taken      = 1'b0;
        prdt_pc_add_op1 = pc;
        prdt_pc_add_op2 = PC_STEP;
        if (dec_i_valid) begin
            if (dec_jal) begin
                prdt_taken      = 1'b1;
                prdt_pc_add_op2 = dec_bjp_imm;
            end else if (dec_jalr) begin
                prdt_taken      = 1'b1;
                prdt_pc_add_op2 = dec_bjp_imm;
                if (rs1_x0)      prdt_pc_add_op1 = '0;
                else if (rs1_x1) prdt_pc_add_op1 = rf2bpu_x1;
                else             prdt_pc_add_op1 = rf2bpu_rs1;
            end else if (dec_bjp) begin
                prdt_taken = dec_bjp_imm[XLEN-1];
                if (dec_bjp_imm[XLEN-1]) prdt_pc_add_op2 = dec_bjp_imm;
            end
        end
    end

    always_comb begin
        bpu2rf_rd_req = (state_q == BPU_ST_REQ);
        bpu2rf_rs1idx = bpu2rf_rd_req ? rs1idx_q : '0;
        bpu_wait      = (jalr_vld & rs1_x1 & x1_dep)
                      | ((state_q == BPU_ST_IDLE) & jalr_xn_vld)
                      | (state_q == BPU_ST_WAIT)
                      | (state_q == BPU_ST_REQ);
        bpu_state_dbg = state_q;
    end

endmodule
